// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and ALU mode/select constants for the ALU sequencer.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;
    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_XOR    = 4'b0110;
    localparam logic [3:0] SEL_PASS_A = 4'b1111;
    localparam logic [3:0] SEL_DEC    = 4'b1111;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x WIDTH register file, two async read ports, load and write-back ports.
module alu_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data
);
    logic [WIDTH-1:0] mem_q [NREGS];

    assign rd_a = mem_q[ra_a];
    assign rd_b = mem_q[ra_b];

    // write-back takes priority over a same-cycle load to the same entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n)
                mem_q[i] <= '0;
            else if (wb_en && wb_addr == AW'(i))
                mem_q[i] <= wb_data;
            else if (ld_en && ld_addr == AW'(i))
                mem_q[i] <= ld_data;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches operands, drives a combinational ALU for cmd_repeat+1 passes,
// writes the result back and returns it over a response handshake.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int CNT_W = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [3:0]       cmd_select,
    input  logic             cmd_carry_in,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [CNT_W-1:0] cmd_repeat,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             alu_mode,
    output logic [3:0]       alu_select,
    output logic             alu_carry_in,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_compare,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_compare
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic             mode_q, mode_d, cin_q, cin_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rd_q, rd_d;
    logic             rc_q, rc_d, rp_q, rp_d;
    logic [WIDTH-1:0] rf_a, rf_b;
    logic             wb_en;

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk(clk), .rst_n(rst_n),
        .ra_a(cmd_src_a), .ra_b(cmd_src_b), .rd_a(rf_a), .rd_b(rf_b),
        .ld_en(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .wb_en(wb_en), .wb_addr(dst_q), .wb_data(alu_result)
    );

    assign cmd_ready    = state_q == IDLE;
    assign rsp_valid    = state_q == RESP;
    assign alu_mode     = mode_q;
    assign alu_select   = sel_q;
    assign alu_carry_in = cin_q;
    assign alu_in_a     = a_q;
    assign alu_in_b     = b_q;
    assign rsp_data     = rd_q;
    assign rsp_carry    = rc_q;
    assign rsp_compare  = rp_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        rc_d    = rc_q;
        rp_d    = rp_q;
        wb_en   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                mode_d  = cmd_mode;
                sel_d   = cmd_select;
                cin_d   = cmd_carry_in;
                a_d     = rf_a;
                b_d     = rf_b;
                dst_d   = cmd_dst;
                cnt_d   = cmd_repeat;
                state_d = EXEC;
            end
            EXEC: if (cnt_q == '0) begin
                rd_d    = alu_result;
                rc_d    = alu_carry_out;
                rp_d    = alu_compare;
                wb_en   = 1'b1;
                state_d = RESP;
            end else begin
                // accumulate: feed the result and carry back as operand A / carry_in
                a_d   = alu_result;
                cin_d = alu_carry_out;
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            rc_q    <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            rc_q    <= rc_d;
            rp_q    <= rp_d;
        end
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-side initiator for the team's combinational 16-bit ALU (mode/select/carry_in in; alu_out/carry_out/compare back).
- Accepts ALU commands over a valid/ready handshake and fetches operands from an internal register file.
- Drives registered ALU inputs and captures the results, optionally iterating (accumulate loop).
- Writes the result back to the register file and returns it on a response handshake.
- Sits between the instruction/control path and the ALU instance.

Parameters:
WIDTH, 16, datapath width; must match the ALU.
NREGS, 8, register-file depth; power of two.
AW, log2(NREGS) = 3, register address width (derived, not overridable).
CNT_W, 4, repeat-count width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_mode  in  1  ALU mode: 0 arithmetic, 1 logic
cmd_select  in  4  ALU select
cmd_carry_in  in  1  initial carry_in
cmd_src_a  in  AW  register address of operand A
cmd_src_b  in  AW  register address of operand B
cmd_dst  in  AW  write-back register address
cmd_repeat  in  CNT_W  extra iterations; total passes = cmd_repeat+1
ld_valid  in  1  direct register-file load strobe
ld_addr  in  AW  load address
ld_data  in  WIDTH  load data
alu_mode  out  1  to ALU mode (registered)
alu_select  out  4  to ALU select (registered)
alu_carry_in  out  1  to ALU carry_in (registered)
alu_in_a  out  WIDTH  to ALU in_a (registered)
alu_in_b  out  WIDTH  to ALU in_b (registered)
alu_result  in  WIDTH  from ALU alu_out
alu_carry_out  in  1  from ALU carry_out
alu_compare  in  1  from ALU compare
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH  final ALU result
rsp_carry  out  1  final carry_out
rsp_compare  out  1  final compare

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; all alu_* outputs 0; rsp_valid=0; rsp_data/carry/compare=0; all register-file entries 0; iteration counter 0.
- cmd_ready = (state==IDLE), driven combinationally from state.
- IDLE:
  - On cmd_valid && cmd_ready, load alu_mode/select/carry_in from the command.
  - Load alu_in_a=rf[src_a] and alu_in_b=rf[src_b] from current contents. A same-cycle ld is not bypassed.
  - Latch dst, set cnt=cmd_repeat, then go to EXEC.
- EXEC: the ALU is combinational, so its outputs are valid within the cycle and are sampled at the end of every EXEC cycle.
  - If cnt==0: capture rsp_data/carry/compare from the ALU, write rf[dst]=alu_result, go to RESP.
  - Else: alu_in_a<=alu_result, alu_carry_in<=alu_carry_out, cnt<=cnt-1, stay in EXEC. alu_in_b, mode and select are held.
- RESP: rsp_valid=1 with rsp_* stable. On rsp_ready go to IDLE; rsp_valid drops the next cycle. Back-to-back commands therefore have a one-cycle IDLE gap.
- Latency: command accepted at edge T gives rsp_valid high from cycle T+2+cmd_repeat.
- Load port: ld_valid writes rf[ld_addr] in any state.
- Simultaneous load and write-back to the same address in one cycle: the write-back wins.
- A load in EXEC to src_a/src_b has no effect on the running operation, since operands are already registered.
- src_a==src_b==dst is legal.
- Arithmetic wraps modulo 2^WIDTH inside the ALU. The sequencer never widens or saturates.
- Reset mid-EXEC/RESP: the operation is abandoned, no write-back occurs, and rsp_valid is 0 on the cycle after reset is sampled.
- alu_* outputs hold their last values in IDLE/RESP; they are only updated on accept or iteration.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, EXEC, RESP};
  - localparams MODE_ARITH=0 and MODE_LOGIC=1;
  - select encodings SEL_ADD=4'b1001, SEL_XOR=4'b0110, SEL_PASS_A (logic)=4'b1111, SEL_DEC=4'b1111 (arith).
- One natural sub-module: alu_regfile, the NREGS×WIDTH register file with two read ports, a load write port and a write-back write port (write-back priority).
- The bench instantiates the real ALU against this block.

Test Plan:
- XOR: load r1=0x1234, r2=0x0F0F; cmd mode=1 sel=0110 src_a=1 src_b=2 dst=3 repeat=0 → rsp_valid at T+2, rsp_data=0x1D3B, rf[3]=0x1D3B.
- Iterated add: r1=0x0003, r2=0x0005; mode=0 sel=1001 dst=4 repeat=3 → 4 EXEC cycles, rsp_valid at T+5, rsp_data=0x0017, rf[4]=0x0017.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stay stable and cmd_ready=0 throughout; after rsp_ready=1, cmd_ready=1 in the next cycle.
- Write collision: in the final EXEC cycle of a dst=3 op, drive ld_valid addr=3 data=0xAAAA → rf[3]=ALU result, not 0xAAAA.
- Wrap: r1=0xFFFF, r2=0x0001, mode=0 sel=1001 → rsp_data=0x0000, rsp_carry equals the ALU carry_out.
- Reset mid-op: assert rst_n=0 during EXEC of a repeat=5 op → next cycle state IDLE, rsp_valid=0, rf[dst] still 0, cmd_ready=1 after release.
